// File: rtl/ibex_l2_rf_pkg.sv
// Shared types and constants for the L2 register-file backing store.
// Imported by the miss controller and its write buffer.
package ibex_l2_rf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_A,
        RD_B,
        RESP
    } l2_state_e;

    localparam int unsigned L1Base   = 12;
    localparam int unsigned L1Size   = 4;
    localparam int unsigned CntWidth = 3;

endpackage

// File: rtl/ibex_l2_rf_wbuf.sv
// One-entry coalescing write buffer for the L2 array.
// Drains whenever no read capture is using the array port.
module ibex_l2_rf_wbuf import ibex_l2_rf_pkg::*; #(
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 capture_i,
    input  logic [4:0]           rd_addr_i,
    output logic                 wr_ready_o,
    output logic                 hit_o,
    output logic [DataWidth-1:0] hit_data_o,
    output logic                 drain_o,
    output logic [4:0]           drain_addr_o,
    output logic [DataWidth-1:0] drain_data_o
);

    logic                 valid_q;
    logic [4:0]           addr_q;
    logic [DataWidth-1:0] data_q;
    logic                 accept;

    assign drain_o      = valid_q && !capture_i;
    assign drain_addr_o = addr_q;
    assign drain_data_o = data_q;

    // Writes to x0 are swallowed, so they never need to wait.
    assign wr_ready_o = !valid_q || drain_o ||
                        (waddr_i == '0) || (waddr_i == addr_q);

    assign accept = we_i && wr_ready_o && (waddr_i != '0);

    assign hit_o      = valid_q && (addr_q == rd_addr_i);
    assign hit_data_o = data_q;

    // Load/coalesce a new entry, or retire the drained one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (accept) begin
            valid_q <= 1'b1;
            addr_q  <= waddr_i;
            data_q  <= wdata_i;
        end else if (drain_o) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ibex_l2_rf_miss_ctrl.sv
// L2 register-file miss controller: serialises operand reads over a
// single-port array and absorbs writes through a coalescing buffer.
module ibex_l2_rf_miss_ctrl import ibex_l2_rf_pkg::*; #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned L2Latency = 2,
    parameter int unsigned NumWords  = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 rd_a_en_i,
    input  logic [4:0]           raddr_a_i,
    input  logic                 rd_b_en_i,
    input  logic [4:0]           raddr_b_i,
    output logic                 rsp_valid_o,
    output logic [DataWidth-1:0] rdata_a_o,
    output logic [DataWidth-1:0] rdata_b_o,
    input  logic                 we_i,
    input  logic [4:0]           waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    output logic                 wr_ready_o,
    output logic                 stall_o
);

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(L2Latency - 1);

    l2_state_e            state_q, state_d;
    logic [CntWidth-1:0]  cnt_q;
    logic                 en_a_q, en_b_q;
    logic [4:0]           addr_a_q, addr_b_q;
    logic [DataWidth-1:0] mem_q [NumWords];

    logic                 req_fire;
    logic                 en_a_d, en_b_d;
    logic                 in_rd;
    logic                 capture;
    logic                 same_ab;
    logic [4:0]           rd_addr;
    logic [DataWidth-1:0] cap_data;

    logic                 hit;
    logic [DataWidth-1:0] hit_data;
    logic                 drain;
    logic [4:0]           drain_addr;
    logic [DataWidth-1:0] drain_data;

    assign req_ready_o = (state_q == IDLE);
    assign req_fire    = req_valid_i && req_ready_o;
    assign rsp_valid_o = (state_q == RESP);

    assign en_a_d = rd_a_en_i && (raddr_a_i != '0);
    assign en_b_d = rd_b_en_i && (raddr_b_i != '0);

    assign in_rd   = (state_q == RD_A) || (state_q == RD_B);
    assign capture = in_rd && (cnt_q == CntLast);
    assign same_ab = en_b_q && (addr_b_q == addr_a_q);
    assign rd_addr = (state_q == RD_B) ? addr_b_q : addr_a_q;

    assign cap_data = hit ? hit_data : mem_q[rd_addr];

    assign stall_o = in_rd || (req_valid_i && (state_q == IDLE)) ||
                     (we_i && !wr_ready_o);

    ibex_l2_rf_wbuf #(
        .DataWidth (DataWidth)
    ) u_wbuf (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .capture_i    (capture),
        .rd_addr_i    (rd_addr),
        .wr_ready_o   (wr_ready_o),
        .hit_o        (hit),
        .hit_data_o   (hit_data),
        .drain_o      (drain),
        .drain_addr_o (drain_addr),
        .drain_data_o (drain_data)
    );

    // Next-state decode for the read sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    if (en_a_d) begin
                        state_d = RD_A;
                    end else if (en_b_d) begin
                        state_d = RD_B;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RD_A: begin
                if (capture) begin
                    state_d = (en_b_q && !same_ab) ? RD_B : RESP;
                end
            end
            RD_B: begin
                if (capture) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latency counter, latched request and operand capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            en_a_q    <= 1'b0;
            en_b_q    <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            rdata_a_o <= '0;
            rdata_b_o <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q || !in_rd) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (req_fire) begin
                en_a_q   <= en_a_d;
                en_b_q   <= en_b_d;
                addr_a_q <= raddr_a_i;
                addr_b_q <= raddr_b_i;
                if (rd_a_en_i && raddr_a_i == '0) begin
                    rdata_a_o <= '0;
                end
                if (rd_b_en_i && raddr_b_i == '0) begin
                    rdata_b_o <= '0;
                end
            end
            if (capture && state_q == RD_A) begin
                rdata_a_o <= cap_data;
                if (same_ab) begin
                    rdata_b_o <= cap_data;
                end
            end
            if (capture && state_q == RD_B) begin
                rdata_b_o <= cap_data;
            end
        end
    end

    // Storage array: cleared on reset, written only by buffer drains.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumWords; i++) begin
                mem_q[i] <= '0;
            end
        end else if (drain) begin
            mem_q[drain_addr] <= drain_data;
        end
    end

endmodule

// File: tb/tb_ibex_l2_rf_miss_ctrl.sv
// Directed bench for the L2 register-file miss controller.
// Latency 2, expected values computed by hand.
module tb_ibex_l2_rf_miss_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        rd_a_en_i;
    logic [4:0]  raddr_a_i;
    logic        rd_b_en_i;
    logic [4:0]  raddr_b_i;
    logic        rsp_valid_o;
    logic [31:0] rdata_a_o;
    logic [31:0] rdata_b_o;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic        wr_ready_o;
    logic        stall_o;

    int n_run  = 0;
    int n_fail = 0;

    ibex_l2_rf_miss_ctrl #(
        .DataWidth (32),
        .L2Latency (2),
        .NumWords  (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .rd_a_en_i   (rd_a_en_i),
        .raddr_a_i   (raddr_a_i),
        .rd_b_en_i   (rd_b_en_i),
        .raddr_b_i   (raddr_b_i),
        .rsp_valid_o (rsp_valid_o),
        .rdata_a_o   (rdata_a_o),
        .rdata_b_o   (rdata_b_o),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .wr_ready_o  (wr_ready_o),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        waddr_i = a;
        wdata_i = d;
        @(negedge clk_i);
        chk("wr_ready", {31'b0, wr_ready_o}, 32'd1);
        step();
        we_i = 1'b0;
        step();
    endtask

    task automatic do_req(input logic ea, input logic [4:0] aa,
                          input logic eb, input logic [4:0] ab,
                          input int lat);
        int n;
        req_valid_i = 1'b1;
        rd_a_en_i   = ea;
        raddr_a_i   = aa;
        rd_b_en_i   = eb;
        raddr_b_i   = ab;
        @(negedge clk_i);
        chk("req_ready", {31'b0, req_ready_o}, 32'd1);
        chk("req_stall", {31'b0, stall_o}, 32'd1);
        step();
        req_valid_i = 1'b0;
        rd_a_en_i   = 1'b0;
        rd_b_en_i   = 1'b0;
        n = 1;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 20) begin
            chk("rd_stall", {31'b0, stall_o}, 32'd1);
            step();
            @(negedge clk_i);
            n++;
        end
        chk("rsp_lat", n, lat);
        chk("resp_stall", {31'b0, stall_o}, 32'd0);
        step();
        chk("rsp_pulse", {31'b0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rd_a_en_i   = 1'b0;
        raddr_a_i   = '0;
        rd_b_en_i   = 1'b0;
        raddr_b_i   = '0;
        we_i        = 1'b0;
        waddr_i     = '0;
        wdata_i     = '0;
        step();
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_ready", {31'b0, req_ready_o}, 32'd1);
        chk("rst_rsp", {31'b0, rsp_valid_o}, 32'd0);
        chk("rst_rda", rdata_a_o, 32'h0);
        chk("rst_rdb", rdata_b_o, 32'h0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        step();

        // single operand A
        write_word(5'd5, 32'hA5A5_0001);
        do_req(1'b1, 5'd5, 1'b0, 5'd0, 3);
        chk("a_only", rdata_a_o, 32'hA5A5_0001);

        // both operands
        write_word(5'd5, 32'h11);
        write_word(5'd20, 32'h22);
        do_req(1'b1, 5'd5, 1'b1, 5'd20, 5);
        chk("ab_a", rdata_a_o, 32'h11);
        chk("ab_b", rdata_b_o, 32'h22);

        // A == B
        write_word(5'd6, 32'h66);
        do_req(1'b1, 5'd6, 1'b1, 5'd6, 3);
        chk("same_a", rdata_a_o, 32'h66);
        chk("same_b", rdata_b_o, 32'h66);

        // address 0 forced to zero, B held
        do_req(1'b1, 5'd0, 1'b0, 5'd0, 1);
        chk("x0_a", rdata_a_o, 32'h0);
        chk("x0_b_hold", rdata_b_o, 32'h66);

        // B only
        do_req(1'b0, 5'd0, 1'b1, 5'd20, 3);
        chk("b_only", rdata_b_o, 32'h22);

        // forwarding from the buffer at capture
        we_i = 1'b1; waddr_i = 5'd7; wdata_i = 32'h1111;
        step();
        req_valid_i = 1'b1; rd_a_en_i = 1'b1; raddr_a_i = 5'd7;
        step();
        req_valid_i = 1'b0; rd_a_en_i = 1'b0;
        wdata_i = 32'hDEAD;
        step();
        we_i = 1'b0;
        step();
        @(negedge clk_i);
        chk("fwd_rsp", {31'b0, rsp_valid_o}, 32'd1);
        chk("fwd_a", rdata_a_o, 32'hDEAD);
        step();
        do_req(1'b1, 5'd7, 1'b0, 5'd0, 3);
        chk("fwd_array", rdata_a_o, 32'hDEAD);

        // coalesce and full buffer during captures
        req_valid_i = 1'b1; rd_a_en_i = 1'b1; raddr_a_i = 5'd5;
        rd_b_en_i = 1'b1; raddr_b_i = 5'd20;
        step();
        req_valid_i = 1'b0; rd_a_en_i = 1'b0; rd_b_en_i = 1'b0;
        we_i = 1'b1; waddr_i = 5'd9; wdata_i = 32'h1;
        @(negedge clk_i);
        chk("co_rdy1", {31'b0, wr_ready_o}, 32'd1);
        step();
        wdata_i = 32'h2;
        @(negedge clk_i);
        chk("co_rdy2", {31'b0, wr_ready_o}, 32'd1);
        step();
        step();
        waddr_i = 5'd10; wdata_i = 32'h10;
        @(negedge clk_i);
        chk("full_rdy", {31'b0, wr_ready_o}, 32'd0);
        chk("full_stall", {31'b0, stall_o}, 32'd1);
        step();
        @(negedge clk_i);
        chk("co_rsp", {31'b0, rsp_valid_o}, 32'd1);
        chk("co_drain_rdy", {31'b0, wr_ready_o}, 32'd1);
        chk("co_stall", {31'b0, stall_o}, 32'd0);
        chk("co_a", rdata_a_o, 32'h11);
        chk("co_b", rdata_b_o, 32'h22);
        step();
        we_i = 1'b0;
        do_req(1'b1, 5'd9, 1'b1, 5'd10, 5);
        chk("co_x9", rdata_a_o, 32'h2);
        chk("co_x10", rdata_b_o, 32'h10);

        // reset during RD_B
        req_valid_i = 1'b1; rd_a_en_i = 1'b1; raddr_a_i = 5'd5;
        rd_b_en_i = 1'b1; raddr_b_i = 5'd20;
        step();
        req_valid_i = 1'b0; rd_a_en_i = 1'b0; rd_b_en_i = 1'b0;
        step();
        we_i = 1'b1; waddr_i = 5'd11; wdata_i = 32'h77;
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        we_i  = 1'b0;
        @(negedge clk_i);
        chk("mr_rsp", {31'b0, rsp_valid_o}, 32'd0);
        chk("mr_ready", {31'b0, req_ready_o}, 32'd1);
        chk("mr_a", rdata_a_o, 32'h0);
        chk("mr_b", rdata_b_o, 32'h0);
        chk("mr_stall", {31'b0, stall_o}, 32'd0);
        step();
        do_req(1'b1, 5'd11, 1'b1, 5'd5, 5);
        chk("mr_wb_gone", rdata_a_o, 32'h0);
        chk("mr_mem_clr", rdata_b_o, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
